// File: rtl/tick_timer_arbiter.sv
// rtl/tick_timer_arbiter.sv - round-robin arbiter for one shared tick timebase; TIMER_ABORT_EN lets a requester drop req to abandon its timer
module tick_timer_arbiter #(
    parameter int TICK_DIV = 1250000,
    parameter int CNT_W    = 21
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [7:0] dur0,
    input  logic [7:0] dur1,
    input  logic [7:0] dur2,
    output logic [2:0] gnt,
    output logic [2:0] done,
    output logic       busy,
    output logic       tick
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] psc;
    logic [7:0]       remaining;
    logic [1:0]       ptr;
    logic [1:0]       owner;
    logic [1:0]       pick;
    logic             pick_vld;
    logic [7:0]       pick_dur;
    logic [1:0]       ptr_adv;
    logic             wrap;
    logic             abort;

    // Scan from the farthest candidate to the nearest so the one closest to ptr wins.
    always_comb begin
        logic [2:0] idx;
        pick     = 2'd0;
        pick_vld = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            idx = {1'b0, ptr} + 3'(i);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end
            if (req[idx[1:0]]) begin
                pick     = idx[1:0];
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        case (pick)
            2'd0:    pick_dur = dur0;
            2'd1:    pick_dur = dur1;
            default: pick_dur = dur2;
        endcase
    end

    assign wrap    = (psc == CNT_W'(TICK_DIV - 1));
    assign ptr_adv = (owner == 2'd2) ? 2'd0 : owner + 2'd1;

`ifdef TIMER_ABORT_EN
    assign abort = (state == RUN) && ((req & gnt) == 3'b000);
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if ((remaining == 8'd0) || (wrap && (remaining == 8'd1))) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            gnt       <= 3'b000;
            done      <= 3'b000;
            busy      <= 1'b0;
            tick      <= 1'b0;
            psc       <= '0;
            remaining <= 8'd0;
            ptr       <= 2'd0;
            owner     <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    tick <= 1'b0;
                    done <= 3'b000;
                    if (pick_vld) begin
                        gnt       <= 3'b001 << pick;
                        owner     <= pick;
                        remaining <= pick_dur;
                        psc       <= '0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    psc  <= wrap ? '0 : psc + CNT_W'(1);
                    tick <= wrap;
                    if (wrap) begin
                        remaining <= remaining - 8'd1;
                    end
                    if (state_nxt == DONE) begin
                        done <= gnt;
                        psc  <= '0;
                    end else if (state_nxt == IDLE) begin
                        // Abandoned timer: release without a completion strobe.
                        gnt  <= 3'b000;
                        busy <= 1'b0;
                        tick <= 1'b0;
                        psc  <= '0;
                        ptr  <= ptr_adv;
                    end
                end
                DONE: begin
                    done <= 3'b000;
                    gnt  <= 3'b000;
                    busy <= 1'b0;
                    tick <= 1'b0;
                    ptr  <= ptr_adv;
                end
                default: begin
                    gnt  <= 3'b000;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// tb/tb_tick_timer_arbiter.sv - scoreboard bench for tick_timer_arbiter with TICK_DIV=4
module tb_tick_timer_arbiter;

    localparam int TD = 4;

    logic       clk_in = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [7:0] dur0, dur1, dur2;
    logic [2:0] gnt, done;
    logic       busy, tick;

    int tests = 0;
    int fails = 0;

    tick_timer_arbiter #(.TICK_DIV(TD), .CNT_W(2)) dut (
        .clk_in(clk_in), .rst(rst), .req(req),
        .dur0(dur0), .dur1(dur1), .dur2(dur2),
        .gnt(gnt), .done(done), .busy(busy), .tick(tick)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0] g;
        int         len;
        int         ticks;
        int         last;
        logic [2:0] d;
        int         doff;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        if (obs !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic push_norm(input logic [2:0] g, input int d);
        exp_t e;
        int   run;
        run     = (d == 0) ? 1 : d * TD;
        e.g     = g;
        e.len   = run + 1;
        e.ticks = d;
        e.last  = (d == 0) ? 0 : run + 1;
        e.d     = g;
        e.doff  = run + 1;
        exp_q.push_back(e);
    endtask

    task automatic push_cut(input logic [2:0] g, input int len, input int ticks, input int last);
        exp_t e;
        e.g     = g;
        e.len   = len;
        e.ticks = ticks;
        e.last  = last;
        e.d     = 3'b000;
        e.doff  = 0;
        exp_q.push_back(e);
    endtask

    // Session monitor: one grant period, from gnt rising to gnt falling.
    logic [2:0] cur_gnt = 3'b000;
    int         off = 0, nticks = 0, last_tick = 0, done_off = 0, ndone = 0;
    logic [2:0] done_val = 3'b000;

    task automatic end_session();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("sess_gnt", 32'(cur_gnt), 32'(e.g));
        check("sess_len", 32'(off), 32'(e.len));
        check("sess_ticks", 32'(nticks), 32'(e.ticks));
        check("sess_last_tick", 32'(last_tick), 32'(e.last));
        check("sess_done", 32'(done_val), 32'(e.d));
        check("sess_done_off", 32'(done_off), 32'(e.doff));
        check("sess_ndone", 32'(ndone), (e.d != 3'b000) ? 32'd1 : 32'd0);
    endtask

    task automatic start_session();
        cur_gnt   = gnt;
        off       = 1;
        nticks    = 0;
        last_tick = 0;
        done_off  = 0;
        ndone     = 0;
        done_val  = 3'b000;
    endtask

    always @(negedge clk_in) begin
        if (gnt != 3'b000) begin
            if (cur_gnt == 3'b000) begin
                start_session();
            end else if (gnt != cur_gnt) begin
                check("idle_gap", 32'(gnt), 32'd0);
                end_session();
                start_session();
            end else begin
                off++;
            end
            check("busy_in_grant", 32'(busy), 32'd1);
            if (tick) begin
                nticks++;
                last_tick = off;
            end
            if (done != 3'b000) begin
                done_val = done_val | done;
                done_off = off;
                ndone++;
            end
        end else begin
            if (cur_gnt != 3'b000) begin
                end_session();
                cur_gnt = 3'b000;
            end
            check("idle_outs", 32'({busy, tick, done}), 32'd0);
        end
    end

    task automatic wait_done(input int lim);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (done == 3'b000 && n < lim);
        check("done_wait", 32'(done != 3'b000), 32'd1);
    endtask

    task automatic wait_gnt(input int lim);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (gnt == 3'b000 && n < lim);
        check("gnt_wait", 32'(gnt != 3'b000), 32'd1);
    endtask

    task automatic drop_req();
        @(posedge clk_in);
        #1 req = 3'b000;
    endtask

    task automatic pulse_reset();
        @(posedge clk_in);
        #2 rst = 1'b0;
        #1 check("reset_outs", 32'({gnt, done, busy, tick}), 32'd0);
        repeat (2) @(posedge clk_in);
        #1 rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b0;
        req  = 3'b000;
        dur0 = 8'd0;
        dur1 = 8'd0;
        dur2 = 8'd0;
        repeat (3) @(posedge clk_in);
        #1 check("reset_state", 32'({gnt, done, busy, tick}), 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk_in);

        // Single request, dur0=3: ticks at RUN cycles 5,9,13, done after 12 RUN cycles.
        #1 dur0 = 8'd3;
        req = 3'b001;
        push_norm(3'b001, 3);
        @(posedge clk_in);
        #1 check("grant_lat", 32'(gnt), 32'(3'b001));
        wait_done(40);
        drop_req();
        repeat (3) @(posedge clk_in);

        // Round-robin from ptr=0 with everyone requesting.
        pulse_reset();
        dur0 = 8'd1;
        dur1 = 8'd1;
        dur2 = 8'd1;
        push_norm(3'b001, 1);
        push_norm(3'b010, 1);
        push_norm(3'b100, 1);
        push_norm(3'b001, 1);
        @(posedge clk_in);
        #1 req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_done(20);
        end
        drop_req();
        repeat (3) @(posedge clk_in);

        // Zero duration: one RUN cycle, no tick.
        #1 dur1 = 8'd0;
        req = 3'b010;
        push_norm(3'b010, 0);
        wait_done(10);
        drop_req();
        repeat (3) @(posedge clk_in);

        // dur change after grant is ignored.
        #1 dur0 = 8'd2;
        req = 3'b001;
        push_norm(3'b001, 2);
        wait_gnt(10);
        dur0 = 8'd9;
        wait_done(40);
        drop_req();
        repeat (3) @(posedge clk_in);

        // Requester 0 drops req after 6 RUN cycles while requester 1 asks.
        #1 dur0 = 8'd5;
        dur1 = 8'd1;
        req  = 3'b001;
`ifdef TIMER_ABORT_EN
        push_cut(3'b001, 7, 1, 5);
`else
        push_norm(3'b001, 5);
`endif
        push_norm(3'b010, 1);
        wait_gnt(10);
        repeat (6) @(posedge clk_in);
        #1 req = 3'b010;
`ifndef TIMER_ABORT_EN
        wait_done(40);
`endif
        wait_done(40);
        drop_req();
        repeat (3) @(posedge clk_in);

        // Reset at RUN cycle 7, then both 0 and 2 request: 0 wins from ptr=0.
        #1 dur0 = 8'd3;
        req = 3'b001;
        push_cut(3'b001, 6, 1, 5);
        wait_gnt(10);
        repeat (6) @(posedge clk_in);
        #2 rst = 1'b0;
        #1 check("midrun_reset_outs", 32'({gnt, done, busy, tick}), 32'd0);
        dur0 = 8'd1;
        dur2 = 8'd1;
        req  = 3'b101;
        repeat (2) @(posedge clk_in);
        #1 check("reset_hold_outs", 32'({gnt, done, busy, tick}), 32'd0);
        rst = 1'b1;
        push_norm(3'b001, 1);
        push_norm(3'b100, 1);
        #1 check("pre_edge_gnt", 32'(gnt), 32'd0);
        @(posedge clk_in);
        #1 check("post_reset_gnt", 32'(gnt), 32'(3'b001));
        wait_done(20);
        wait_done(20);
        drop_req();
        repeat (4) @(posedge clk_in);

        #1 check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tick_timer_arbiter.md
TICK_TIMER_ARBITER -- requirements
Module: tick_timer_arbiter

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1250000, meaning clk_in cycles per tick (50 ms at 25 MHz); legal range 2..2^21.
REQ-002 The block SHALL have parameter CNT_W, default 21, meaning prescaler width; CNT_W SHALL be wide enough to hold TICK_DIV-1.
REQ-003 The block SHALL have port clk_in, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, 3 bits: per-requester timer request, level, held until done or abandon.
REQ-006 The block SHALL have ports dur0, dur1, dur2, input, 8 bits each: timeout in ticks for requester 0/1/2.
REQ-007 The block SHALL have port gnt, output, 3 bits: one-hot owner of the shared timebase, all-zero when idle.
REQ-008 The block SHALL have port done, output, 3 bits: one-cycle completion strobe to the owner.
REQ-009 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-010 The block SHALL have port tick, output, 1 bit: registered one-cycle strobe per completed prescaler period in RUN.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE; all outputs are registered.
REQ-012 In IDLE with req!=0, the next edge SHALL select a winner round-robin starting at ptr, enter RUN, set gnt one-hot, load remaining=dur of winner, and clear the prescaler.
REQ-013 ptr SHALL be reset to 0 and set to (winner+1) mod 3 on every exit from RUN or DONE to IDLE.
REQ-014 In RUN, the prescaler SHALL increment each cycle; at TICK_DIV-1 it wraps to 0, tick is asserted the next cycle, and remaining decrements.
REQ-015 When a wrap occurs with remaining==1, or on RUN entry with remaining==0, the next state SHALL be DONE.
REQ-016 DONE SHALL last exactly one cycle with done[winner]=1 and gnt held; the next state is IDLE with gnt=0.
REQ-017 A request SHALL be complete after dur x TICK_DIV cycles in RUN; dur=0 SHALL give one RUN cycle, then DONE.
REQ-018 Requests arriving while busy SHALL wait, with no queueing beyond the req level; IDLE lasts at least one cycle between grants.
REQ-019 Changes to dur inputs after grant SHALL be ignored, since only the value latched at entry counts.
REQ-020 tick SHALL be 0 outside RUN and the prescaler SHALL hold 0 outside RUN.

Reset
REQ-021 Reset asserted at any time, including mid-RUN, SHALL force IDLE, gnt=0, done=0, busy=0, tick=0, prescaler=0, remaining=0 and ptr=0 immediately, with no done strobe issued.
REQ-022 After rst deasserts, the first grant SHALL occur no earlier than the first rising edge with rst high.

Configuration
REQ-023 With TIMER_ABORT_EN defined, req[winner] low in RUN SHALL move the FSM to IDLE on the next edge with no done strobe and ptr advanced.
REQ-024 Without TIMER_ABORT_EN, req changes in RUN SHALL be ignored and the timer always runs to DONE.

Verification (TICK_DIV=4)
REQ-025 Single request: req=001, dur0=3 -> gnt=001 one cycle later; tick pulses at RUN cycles 5, 9, 13; done=001 for one cycle after 12 RUN cycles; then gnt=000.
REQ-026 Round-robin: req=111 held, all dur=1 -> grants in order 001, 010, 100, 001, with at least one IDLE cycle between each.
REQ-027 Zero duration: req=010, dur1=0 -> one RUN cycle, then done=010, with no tick.
REQ-028 Abort with TIMER_ABORT_EN: req=001, dur0=5, req dropped after 6 RUN cycles -> IDLE next cycle, no done, and the next grant is 010 if req=010.
REQ-029 Reset mid-RUN: rst low at RUN cycle 7 -> all outputs 0 immediately, and after release req=100 is granted before 001 only per ptr=0 ordering (001 first if both are requested).
REQ-030 Late dur change: dur0 changed from 2 to 9 after grant -> done still after 8 RUN cycles.
